// File: rtl/frog_game_ctrl.sv
// Game-state controller for the frog game: tracks lives, score and level, gates the
// collision detector and issues frog respawn pulses and the game-over flag.
module frog_game_ctrl #(
    parameter int LIVES_INIT   = 3,
    parameter int HIT_FRAMES   = 60,
    parameter int GRACE_FRAMES = 90,
    parameter int SCORE_W      = 10,
    parameter int GOAL_POINTS  = 10
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic               frame_tick_i,
    input  logic               start_i,
    input  logic               collision_i,
    input  logic               goal_i,
    output logic               collision_en_o,
    output logic               frog_reset_o,
    output logic [2:0]         lives_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [2:0]         level_o,
    output logic [2:0]         state_o,
    output logic               game_over_o
);

    localparam int MAX_FRAMES = (HIT_FRAMES > GRACE_FRAMES) ? HIT_FRAMES : GRACE_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

    localparam logic [CNT_W-1:0]   HIT_CNT    = CNT_W'(HIT_FRAMES);
    localparam logic [CNT_W-1:0]   GRACE_CNT  = CNT_W'(GRACE_FRAMES);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [2:0]         LIVES_LOAD = 3'(LIVES_INIT);
    localparam logic [2:0]         LEVEL_MAX  = 3'd7;
    localparam logic [SCORE_W:0]   GOAL_EXT   = (SCORE_W + 1)'(GOAL_POINTS);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PLAY     = 3'd1,
        ST_HIT      = 3'd2,
        ST_RESPAWN  = 3'd3,
        ST_GAMEOVER = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         level_q, level_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic               start_q, start_d;
    logic               frog_reset_q, frog_reset_d;
    logic               collision_en_q, collision_en_d;
    logic               game_over_q, game_over_d;

    logic               start_rise;
    logic               start_game;
    logic               play_hit;
    logic               play_goal;
    logic               frame_adv;
    logic [CNT_W-1:0]   cnt_inc;
    logic               hold_done;
    logic               grace_done;
    logic [SCORE_W:0]   score_sum;
    logic               respawn_req;

    // Events are only honoured in the states that own them; a stale collision flag
    // arriving just after PLAY is left is therefore dropped.
    assign start_rise = start_i & ~start_q;
    assign start_game = start_rise & ((state_q == ST_IDLE) | (state_q == ST_GAMEOVER));
    assign play_hit   = (state_q == ST_PLAY) & collision_i;
    assign play_goal  = (state_q == ST_PLAY) & goal_i & ~collision_i;
    assign frame_adv  = frame_tick_i & ((state_q == ST_HIT) | (state_q == ST_RESPAWN));
    assign cnt_inc    = frame_cnt_q + CNT_ONE;
    assign hold_done  = frame_adv & (state_q == ST_HIT) & (cnt_inc == HIT_CNT);
    assign grace_done = frame_adv & (state_q == ST_RESPAWN) & (cnt_inc == GRACE_CNT);
    assign score_sum  = {1'b0, score_q} + GOAL_EXT;

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state_q        <= ST_IDLE;
            lives_q        <= LIVES_LOAD;
            score_q        <= '0;
            level_q        <= 3'd1;
            frame_cnt_q    <= '0;
            start_q        <= 1'b0;
            frog_reset_q   <= 1'b0;
            collision_en_q <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            lives_q        <= lives_d;
            score_q        <= score_d;
            level_q        <= level_d;
            frame_cnt_q    <= frame_cnt_d;
            start_q        <= start_d;
            frog_reset_q   <= frog_reset_d;
            collision_en_q <= collision_en_d;
            game_over_q    <= game_over_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start_rise) state_d = ST_PLAY;
            ST_PLAY: begin
                if (play_hit) begin
                    state_d = ST_HIT;
                end else if (play_goal) begin
                    state_d = ST_RESPAWN;
                end
            end
            ST_HIT:      if (hold_done) state_d = (lives_q == 3'd0) ? ST_GAMEOVER : ST_RESPAWN;
            ST_RESPAWN:  if (grace_done) state_d = ST_PLAY;
            ST_GAMEOVER: if (start_rise) state_d = ST_PLAY;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_o.
    always_comb begin
        lives_d     = lives_q;
        score_d     = score_q;
        level_d     = level_q;
        frame_cnt_d = frame_cnt_q;
        start_d     = start_i;

        if (start_game) begin
            lives_d = LIVES_LOAD;
            score_d = '0;
            level_d = 3'd1;
        end else if (play_hit) begin
            lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
        end else if (play_goal) begin
            score_d = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
            level_d = (level_q == LEVEL_MAX) ? LEVEL_MAX : level_q + 3'd1;
        end

        if (state_d != state_q) begin
            frame_cnt_d = '0;
        end else if (frame_adv) begin
            frame_cnt_d = cnt_inc;
        end

        // A respawn request right after a start pulse is merged into that pulse.
        respawn_req    = start_game | play_goal | (hold_done & (lives_q != 3'd0));
        frog_reset_d   = respawn_req & ~frog_reset_q;
        collision_en_d = (state_d == ST_PLAY);
        game_over_d    = (state_d == ST_GAMEOVER);
    end

    assign collision_en_o = collision_en_q;
    assign frog_reset_o   = frog_reset_q;
    assign lives_o        = lives_q;
    assign score_o        = score_q;
    assign level_o        = level_q;
    assign state_o        = state_q;
    assign game_over_o    = game_over_q;

endmodule
